// File: rtl/dp_issue_if.sv
// Bus between the issue controller and its environment: instruction handshake,
// ALU drive/response and register-file write-back. slave = controller side.
interface dp_issue_if #(
  parameter int WIDTH = 32
);
  // Instruction handshake: an instruction transfers on a rising edge where
  // instr_valid and instr_ready are both high; instr_ready is high only in IDLE,
  // and instr/instr_valid are don't-care whenever instr_ready is low.
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;

  logic [3:0]       operation_select;
  logic             alu_carry_in;
  logic             alu_src_imm;
  logic [3:0]       rn_addr;
  logic [WIDTH-1:0] alu_result;
  logic             alu_n;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;

  logic [3:0]       rd_addr;
  logic [WIDTH-1:0] wb_data;
  logic             reg_write;
  logic [3:0]       flags;
  logic             done;
  logic             undef;

  // FSM state: 0 IDLE, 1 DECODE, 2 EXECUTE, 3 WRITEBACK
  logic [1:0]       state_dbg;

  modport slave (
    input  instr_valid, instr, alu_result, alu_n, alu_z, alu_c, alu_v,
    output instr_ready, operation_select, alu_carry_in, alu_src_imm, rn_addr,
           rd_addr, wb_data, reg_write, flags, done, undef, state_dbg
  );

  modport master (
    output instr_valid, instr, alu_result, alu_n, alu_z, alu_c, alu_v,
    input  instr_ready, operation_select, alu_carry_in, alu_src_imm, rn_addr,
           rd_addr, wb_data, reg_write, flags, done, undef, state_dbg
  );
endinterface

// File: rtl/dp_issue_ctrl.sv
// Multi-cycle issue controller for ARM-style data-processing instructions:
// condition check, ALU drive, result capture, register write-back and NZCV update.
module dp_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  dp_issue_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [3:0]       cond_q;
  logic             imm_q;
  logic [3:0]       cmd_q;
  logic             s_q;
  logic [3:0]       rn_q;
  logic [3:0]       rd_q;
  logic [WIDTH-1:0] wb_q;
  logic [3:0]       stage_q;
  logic [3:0]       flags_q;

  logic             ready_c;
  logic             done_c;
  logic             undef_c;
  logic             reg_write_c;
  logic [3:0]       op_c;

  logic             cmd_undef;
  logic             is_cmp;
  logic             is_arith;
  logic             cond_ok;
  logic             flag_wr;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^{bus.instr[27:26], bus.instr[11:0]};

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = !cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cf && !z;
      4'h9:    cond_pass = !cf || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign cmd_undef = (cmd_q == 4'b1000) || (cmd_q == 4'b1001) || (cmd_q == 4'b1011);
  assign is_cmp    = (cmd_q == 4'b1010);
  assign is_arith  = ((cmd_q >= 4'b0010) && (cmd_q <= 4'b0111)) || is_cmp;
  assign cond_ok   = cond_pass(cond_q, flags_q);
  assign flag_wr   = (state == S_WRITEBACK) && (s_q || is_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ready_c     = 1'b0;
    done_c      = 1'b0;
    undef_c     = 1'b0;
    reg_write_c = 1'b0;
    op_c        = 4'b0000;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        // An unsupported command is reported even when its condition fails.
        if (cmd_undef) begin
          undef_c  = 1'b1;
          done_c   = 1'b1;
          state_nx = S_IDLE;
        end else if (!cond_ok) begin
          done_c   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        op_c     = cmd_q;
        state_nx = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        reg_write_c = !is_cmp;
        done_c      = 1'b1;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q  <= 4'b0;
      imm_q   <= 1'b0;
      cmd_q   <= 4'b0;
      s_q     <= 1'b0;
      rn_q    <= 4'b0;
      rd_q    <= 4'b0;
      wb_q    <= '0;
      stage_q <= 4'b0;
      flags_q <= 4'b0;
    end else begin
      if ((state == S_IDLE) && bus.instr_valid) begin
        cond_q <= bus.instr[31:28];
        imm_q  <= bus.instr[25];
        cmd_q  <= bus.instr[24:21];
        s_q    <= bus.instr[20];
        rn_q   <= bus.instr[19:16];
        rd_q   <= bus.instr[15:12];
      end
      if (state == S_EXECUTE) begin
        wb_q    <= bus.alu_result;
        stage_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
      end
      // Logical and move commands leave C and V untouched.
      if (flag_wr) begin
        if (is_arith) flags_q <= stage_q;
        else          flags_q <= {stage_q[3:2], flags_q[1:0]};
      end
    end
  end

  assign bus.instr_ready      = ready_c;
  assign bus.operation_select = op_c;
  assign bus.alu_carry_in     = flags_q[1];
  assign bus.alu_src_imm      = imm_q;
  assign bus.rn_addr          = rn_q;
  assign bus.rd_addr          = rd_q;
  assign bus.wb_data          = wb_q;
  assign bus.reg_write        = reg_write_c;
  assign bus.flags            = flags_q;
  assign bus.done             = done_c;
  assign bus.undef            = undef_c;
  assign bus.state_dbg        = state;

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Directed bench for dp_issue_ctrl: each task runs one scenario and checks
// hand-computed expectations inline.
module tb_dp_issue_ctrl;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  dp_issue_if #(.WIDTH(WIDTH)) bus();

  dp_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-instruction observations, cycle k counted from the accept edge.
  int          done_cyc, undef_cyc, wr_cnt, exec_cnt, ready_busy;
  logic [3:0]  op_seen;
  logic [3:0]  wr_rd;
  logic [31:0] wr_data;
  logic        carry_seen;

  task automatic run_instr(input logic [31:0] ins, input logic [31:0] res,
                           input logic [3:0] nzcv);
    bus.alu_result = res;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    done_cyc = 0; undef_cyc = 0; wr_cnt = 0; exec_cnt = 0; ready_busy = 0;
    op_seen = 4'hx; wr_rd = 4'hx; wr_data = 32'hx; carry_seen = 1'bx;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) carry_seen = bus.alu_carry_in;
      if (bus.state_dbg == 2'd2) begin
        exec_cnt++;
        op_seen = bus.operation_select;
      end
      if (bus.instr_ready) ready_busy++;
      if (bus.reg_write) begin
        wr_cnt++;
        wr_rd   = bus.rd_addr;
        wr_data = bus.wb_data;
      end
      if (bus.undef && undef_cyc == 0) undef_cyc = k;
      if (bus.done) begin
        done_cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0;
    bus.alu_result = 32'h0;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.instr_ready, bus.operation_select, bus.alu_carry_in, bus.alu_src_imm,
         bus.rn_addr, bus.rd_addr, bus.wb_data, bus.reg_write, bus.flags,
         bus.done, bus.undef} !== {1'b1, 53'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: flags=%b wb=%h ready=%b done=%b rw=%b, required ready=1 rest 0",
               bus.flags, bus.wb_data, bus.instr_ready, bus.done, bus.reg_write);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.instr_ready !== 1'b1 || bus.state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: ready=%b state=%0d required 1/0", bus.instr_ready, bus.state_dbg);
    end
  endtask

  task automatic test_add_flags();
    run_instr(32'hE0910002, 32'h0000_0000, 4'b0110);
    tests_run++;
    if (exec_cnt !== 1 || op_seen !== 4'b0100) begin
      tests_failed++;
      $display("FAIL add_opsel: exec=%0d op=%b required 1/0100", exec_cnt, op_seen);
    end
    tests_run++;
    if (wr_cnt !== 1 || wr_rd !== 4'd0 || wr_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL add_write: cnt=%0d rd=%0d data=%h required 1/0/0", wr_cnt, wr_rd, wr_data);
    end
    tests_run++;
    if (done_cyc !== 3 || ready_busy !== 0) begin
      tests_failed++;
      $display("FAIL add_latency: done_cyc=%0d busy_ready=%0d required 3/0", done_cyc, ready_busy);
    end
    tests_run++;
    if (bus.flags !== 4'b0110) begin
      tests_failed++;
      $display("FAIL add_flags: got %b required 0110", bus.flags);
    end
  endtask

  task automatic test_compare();
    run_instr(32'hE1510002, 32'hFFFF_FFFF, 4'b1000);
    tests_run++;
    if (op_seen !== 4'b1010 || done_cyc !== 3) begin
      tests_failed++;
      $display("FAIL cmp_opsel: op=%b done_cyc=%0d required 1010/3", op_seen, done_cyc);
    end
    tests_run++;
    if (wr_cnt !== 0) begin
      tests_failed++;
      $display("FAIL cmp_nowrite: writes=%0d required 0", wr_cnt);
    end
    tests_run++;
    if (bus.flags !== 4'b1000) begin
      tests_failed++;
      $display("FAIL cmp_flags: got %b required 1000", bus.flags);
    end
  endtask

  task automatic test_cond_skip();
    run_instr(32'h01A03004, 32'h0000_AAAA, 4'b0100);
    tests_run++;
    if (done_cyc !== 1 || exec_cnt !== 0 || wr_cnt !== 0 || undef_cyc !== 0) begin
      tests_failed++;
      $display("FAIL skip_eq: done_cyc=%0d exec=%0d writes=%0d undef=%0d required 1/0/0/0",
               done_cyc, exec_cnt, wr_cnt, undef_cyc);
    end
    tests_run++;
    if (bus.flags !== 4'b1000) begin
      tests_failed++;
      $display("FAIL skip_flags: got %b required 1000", bus.flags);
    end
    run_instr(32'hE0910002, 32'h0000_0000, 4'b0100);
    tests_run++;
    if (bus.flags !== 4'b0100) begin
      tests_failed++;
      $display("FAIL setz_flags: got %b required 0100", bus.flags);
    end
    run_instr(32'h01A03004, 32'h1234_5678, 4'b1001);
    tests_run++;
    if (op_seen !== 4'b1101 || done_cyc !== 3) begin
      tests_failed++;
      $display("FAIL moveq_opsel: op=%b done_cyc=%0d required 1101/3", op_seen, done_cyc);
    end
    tests_run++;
    if (wr_cnt !== 1 || wr_rd !== 4'd3 || wr_data !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL moveq_write: cnt=%0d rd=%0d data=%h required 1/3/12345678", wr_cnt, wr_rd, wr_data);
    end
    tests_run++;
    if (bus.flags !== 4'b0100) begin
      tests_failed++;
      $display("FAIL moveq_flags: got %b required 0100", bus.flags);
    end
  endtask

  task automatic test_logical_keeps_cv();
    run_instr(32'hE0965007, 32'h0000_0010, 4'b0011);
    tests_run++;
    if (bus.flags !== 4'b0011 || wr_rd !== 4'd5 || wr_data !== 32'h10) begin
      tests_failed++;
      $display("FAIL adds_setup: flags=%b rd=%0d data=%h required 0011/5/00000010", bus.flags, wr_rd, wr_data);
    end
    run_instr(32'hE0121003, 32'h8000_0000, 4'b1000);
    tests_run++;
    if (carry_seen !== 1'b1 || exec_cnt !== 1 || op_seen !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ands_drive: carry_in=%b exec=%0d op=%b required 1/1/0000", carry_seen, exec_cnt, op_seen);
    end
    tests_run++;
    if (wr_cnt !== 1 || wr_rd !== 4'd1 || wr_data !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL ands_write: cnt=%0d rd=%0d data=%h required 1/1/80000000", wr_cnt, wr_rd, wr_data);
    end
    tests_run++;
    if (bus.flags !== 4'b1011) begin
      tests_failed++;
      $display("FAIL ands_flags: got %b required 1011", bus.flags);
    end
  endtask

  task automatic test_undef();
    run_instr(32'hE1110002, 32'h0000_5555, 4'b1111);
    tests_run++;
    if (undef_cyc !== 1 || done_cyc !== 1) begin
      tests_failed++;
      $display("FAIL undef_pulse: undef_cyc=%0d done_cyc=%0d required 1/1", undef_cyc, done_cyc);
    end
    tests_run++;
    if (exec_cnt !== 0 || wr_cnt !== 0 || bus.flags !== 4'b1011) begin
      tests_failed++;
      $display("FAIL undef_quiet: exec=%0d writes=%0d flags=%b required 0/0/1011", exec_cnt, wr_cnt, bus.flags);
    end
  endtask

  task automatic test_back_to_back();
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready: got %b required 1", bus.instr_ready);
    end
    run_instr(32'hE0965007, 32'h0000_0020, 4'b0010);
    tests_run++;
    if (carry_seen !== 1'b1 || done_cyc !== 3 || wr_data !== 32'h20) begin
      tests_failed++;
      $display("FAIL b2b_run: carry_in=%b done_cyc=%0d data=%h required 1/3/00000020", carry_seen, done_cyc, wr_data);
    end
    tests_run++;
    if (bus.flags !== 4'b0010 || bus.alu_carry_in !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_flags: flags=%b carry_in=%b required 0010/1", bus.flags, bus.alu_carry_in);
    end
  endtask

  task automatic test_reset_execute();
    int done_seen;
    done_seen = 0;
    bus.alu_result = 32'hDEAD_BEEF;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = 4'b1111;
    bus.instr = 32'hE0910002;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.operation_select !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rstx_in_execute: op=%b required 0100", bus.operation_select);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.instr_ready, bus.operation_select, bus.alu_carry_in, bus.alu_src_imm,
         bus.rn_addr, bus.rd_addr, bus.wb_data, bus.reg_write, bus.flags,
         bus.done, bus.undef} !== {1'b1, 53'b0}) begin
      tests_failed++;
      $display("FAIL rstx_async: op=%b flags=%b wb=%h ready=%b rw=%b done=%b, required ready=1 rest 0",
               bus.operation_select, bus.flags, bus.wb_data, bus.instr_ready, bus.reg_write, bus.done);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.reg_write) done_seen++;
    end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++;
      $display("FAIL rstx_no_done: pulses=%0d required 0", done_seen);
    end
    tests_run++;
    if (bus.instr_ready !== 1'b1 || bus.flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rstx_after: ready=%b flags=%b required 1/0000", bus.instr_ready, bus.flags);
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_compare();
    test_cond_skip();
    test_logical_keeps_cv();
    test_undef();
    test_back_to_back();
    test_reset_execute();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dp_issue_ctrl.md
Name: dp_issue_ctrl

Overview:
- Multi-cycle issue controller that sits on the driving side of the datapath ALU.
- Accepts one ARM-style data-processing instruction and checks its condition field against an internal NZCV register.
- Drives the ALU operation select and carry-in, captures the ALU result and flags, then issues register write-back and the flag update.
- Sits between the instruction register and the register file / ALU in the lab processor.

Parameters:
- WIDTH, 32, datapath width of the ALU result bus.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction presented
- instr  input  32  instruction word: [31:28] cond, [25] I, [24:21] cmd, [20] S, [19:16] Rn, [15:12] Rd
- instr_ready  output  1  high only in IDLE
- operation_select  output  4  ALU command, equal to latched cmd during EXECUTE, 4'b0000 otherwise
- alu_carry_in  output  1  current C flag
- alu_src_imm  output  1  latched I bit
- rn_addr  output  4  latched Rn
- alu_result  input  WIDTH  ALU result
- alu_n, alu_z, alu_c, alu_v  input  1 each  ALU flags
- rd_addr  output  4  latched Rd
- wb_data  output  WIDTH  captured result
- reg_write  output  1  one-cycle register-file write strobe
- flags  output  4  NZCV register, bit 3 = N
- done  output  1  one-cycle completion pulse
- undef  output  1  one-cycle pulse for an unsupported cmd

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state IDLE, flags 0, wb_data 0, all latched fields 0, all strobes 0.
- States: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE:
  - instr_ready = 1.
  - On instr_valid, latch all instr fields and go to DECODE.
  - Without instr_valid, stay in IDLE.
- DECODE: evaluate cond against flags using ARM codes 0000..1110; 1111 = never.
  - Cmd in {1000, 1001, 1011}: pulse undef and done, go to IDLE, no write.
  - Condition false: pulse done, go to IDLE; flags unchanged.
  - Otherwise: go to EXECUTE.
  - Unsupported cmd takes priority over the condition result.
- EXECUTE:
  - Drive operation_select = cmd.
  - At the clock edge, capture alu_result into wb_data and alu_n/z/c/v into staging registers.
  - Go to WRITEBACK.
- WRITEBACK:
  - reg_write = 1 unless cmd = 1010 (compare).
  - Pulse done, go to IDLE.
  - Flag update at the edge leaving WRITEBACK, applied when S = 1 or cmd = 1010:
    - Arithmetic cmds (0010..0111, 1010): write N, Z, C, V.
    - Logical and move cmds (0000, 0001, 1100..1111): write N and Z only; C and V retain their values.
- Latency: accept edge to done = 3 cycles for an executed instruction, 1 cycle for a skipped or undefined one.
- Throughput: the next instruction is accepted in the cycle after done.
- alu_carry_in always reflects the registered C flag, so ADC/SBC/RSC consume the pre-instruction carry.
- Reset mid-instruction: return to IDLE immediately. Any pending write or flag update is dropped and no done pulse is issued.
- instr and instr_valid are ignored outside IDLE.

Test Plan:
- ADD with flag set:
  - Stimulus: reset, then instr = E0910002 (ADDS R0,R1,R2), alu_result = 0x00000000, alu_z = 1, alu_c = 1.
  - Required: operation_select = 0100 in EXECUTE; reg_write with rd_addr = 0 and wb_data = 0; flags = 0110 after done; done exactly 3 cycles after accept.
- Compare:
  - Stimulus: instr = E1510002 (CMP R1,R2), alu_n = 1.
  - Required: operation_select = 1010; no reg_write; flags = 1000.
- Conditional skip:
  - Stimulus: with Z = 0, instr = 01A03004 (MOVEQ R3,R4).
  - Required: done in the DECODE cycle; no EXECUTE; no reg_write; flags unchanged.
  - Repeat with Z = 1: required operation_select = 1101 and reg_write to rd_addr = 3.
- Logical op preserves C/V:
  - Stimulus: flags = 0011, then ANDS giving result 0x80000000.
  - Required: flags = 1011 after done.
- Undefined command:
  - Stimulus: instr = E1110002 (cmd 1000).
  - Required: undef and done pulse one cycle after accept; flags and register file untouched.
- Reset in EXECUTE:
  - Stimulus: assert reset while operation_select = 0100.
  - Required: all outputs reach reset values without waiting for a clock edge; no done pulse; instr_ready = 1 after reset is released.
